mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the memory data width.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have a port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: request from requester 0 or 1.
REQ-006 The block SHALL have ports wr0 and wr1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr0 and addr1, input, ADDR_WIDTH bits each: request address.
REQ-008 The block SHALL have ports wdata0 and wdata1, input, DATA_WIDTH bits each: write data.
REQ-009 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle request-accepted pulse.
REQ-010 The block SHALL have ports rvalid0 and rvalid1, output, 1 bit each: one-cycle read-data-valid pulse.
REQ-011 The block SHALL have a port rdata, output, DATA_WIDTH bits: read data shared by both requesters, qualified by rvalid0 or rvalid1.
REQ-012 The block SHALL have a port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have ports mem_en, mem_wr, mem_addr and mem_wdata, outputs of 1, 1, ADDR_WIDTH and DATA_WIDTH bits: the memory command.
REQ-014 The block SHALL have ports mem_rdata (DATA_WIDTH bits) and mem_valid (1 bit), inputs: memory read data and valid. The memory updates them on the clock edge that samples a read command.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT_RD and RESP, with transitions:
  - IDLE->ISSUE when req0|req1.
  - ISSUE->IDLE for a write.
  - ISSUE->WAIT_RD for a read.
  - WAIT_RD->RESP unconditionally.
  - RESP->IDLE unconditionally.
REQ-016 Requests SHALL be sampled only in IDLE; req, wr, addr and wdata presented in any other state are ignored until the FSM returns to IDLE.
REQ-017 Single request in IDLE: that requester SHALL be selected.
REQ-018 Both requests in IDLE: the requester not served last SHALL be selected (round-robin); a pointer last_served SHALL update on every selection.
REQ-019 On the IDLE->ISSUE edge, the selected requester's wr, addr and wdata SHALL be registered into mem_wr, mem_addr and mem_wdata.
REQ-020 mem_en SHALL be 1 exactly during the ISSUE cycle and 0 in all other states; mem_wr, mem_addr and mem_wdata SHALL hold their values until the next selection.
REQ-021 The selected requester's gnt SHALL be 1 exactly during the ISSUE cycle; the other gnt SHALL be 0; the requester may drop or change its req after the gnt cycle.
REQ-022 In WAIT_RD, the block SHALL capture mem_rdata into rdata.
REQ-023 In RESP, the block SHALL pulse rvalid for the requester that issued the read, for one cycle, with rdata stable.
REQ-024 rdata SHALL hold its last captured value until the next WAIT_RD.
REQ-025 If mem_valid is 0 in WAIT_RD, the block SHALL still capture mem_rdata and complete RESP; no retry.
REQ-026 Latency: write = 2 cycles from req sampled to the gnt cycle; read = rvalid 3 cycles after the gnt cycle; minimum request spacing is 2 cycles for writes and 4 cycles for reads.
REQ-027 A requester holding req continuously SHALL be re-granted at the next IDLE; with both holding req, grants SHALL strictly alternate 0,1,0,1.
REQ-028 busy SHALL be 1 in ISSUE, WAIT_RD and RESP, and 0 in IDLE.

Reset
REQ-029 When rst=1 at a clock edge, in any state, the block SHALL go to IDLE and drive gnt0=gnt1=rvalid0=rvalid1=mem_en=mem_wr=busy=0 and mem_addr=0, mem_wdata=0, rdata=0.
REQ-030 Reset SHALL set last_served=1, so requester 0 wins the first contention.
REQ-031 Reset mid-read SHALL discard the in-flight response: no rvalid after reset.

Verification
REQ-032 Reset then req0=1, wr0=1, addr0=3, wdata0=0xDEADBEEF -> next cycle gnt0=1, mem_en=1, mem_wr=1, mem_addr=3, mem_wdata=0xDEADBEEF; then IDLE.
REQ-033 Read addr0=3 (memory holds 0xDEADBEEF) -> gnt0 in cycle T, rvalid0=1 with rdata=0xDEADBEEF at T+3; rvalid1 stays 0.
REQ-034 After reset, req0 and req1 held high (both writes) -> grants gnt0, gnt1, gnt0, gnt1 on cycles 1, 3, 5, 7.
REQ-035 req1 asserted during a requester-0 read in WAIT_RD -> no gnt1 until IDLE; gnt1 in the cycle after RESP+1; rdata is unchanged until requester 1's read completes.
REQ-036 rst=1 in WAIT_RD -> next cycle all outputs 0 and busy=0; no rvalid is ever produced for that read.
REQ-037 Read while mem_valid=0 (stub) with mem_rdata=0x12345678 -> rvalid0 pulse with rdata=0x12345678.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of a single-port memory. One transaction is
// in flight at a time: a request is accepted in IDLE, the memory command is
// issued for exactly one cycle, and reads return their data through a shared
// rdata bus qualified by a per-requester rvalid pulse. When both requesters
// ask at once, the one that was not served last wins (round-robin).
//
// Transaction timing (cycle T is the grant cycle):
//   write : req sampled in IDLE -> gnt/mem_en in T -> IDLE in T+1
//   read  : gnt/mem_en in T -> WAIT_RD in T+1 (memory data captured)
//           -> RESP in T+2 -> rvalid pulse in T+3 (FSM already in IDLE)
//
// Parameters
//   ADDR_WIDTH : memory address width
//   DATA_WIDTH : memory data width
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   req0/req1           : request from requester 0/1 (sampled only in IDLE)
//   wr0/wr1             : 1 = write, 0 = read
//   addr0/addr1         : request address
//   wdata0/wdata1       : write data
//   gnt0/gnt1           : one-cycle accept pulse (during the ISSUE cycle)
//   rvalid0/rvalid1     : one-cycle read-data-valid pulse
//   rdata               : read data shared by both requesters
//   busy                : high whenever the FSM is not in IDLE
//   mem_en/mem_wr       : memory command strobe and direction
//   mem_addr/mem_wdata  : memory command address and write data
//   mem_rdata/mem_valid : memory read data and valid (valid is not used;
//                         data is taken in WAIT_RD unconditionally)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  state_reg;
  logic                    last_served_reg;  // requester granted most recently
  logic                    owner_reg;        // requester of the transaction in flight
  logic [1:0]              gnt_reg;
  logic [1:0]              rvalid_reg;
  logic                    mem_en_reg;
  logic                    mem_wr_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  // Requester inputs gathered into indexable form.
  logic [1:0]              req_vec;
  logic [1:0]              wr_vec;
  logic [ADDR_WIDTH-1:0]   addr_arr  [2];
  logic [DATA_WIDTH-1:0]   wdata_arr [2];

  assign req_vec      = {req1, req0};
  assign wr_vec       = {wr1, wr0};
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // Round-robin selection: a requester wins if it asks and either the other
  // one is silent or the other one was the last to be served. With both
  // asking, exactly one term is true because last_served_reg names only one.
  logic [1:0] sel_onehot;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      assign sel_onehot[gi] = req_vec[gi] &
                              (~req_vec[1-gi] | (last_served_reg != 1'(gi)));
    end
  endgenerate

  logic any_req;
  logic sel_idx;

  assign any_req = |req_vec;
  assign sel_idx = sel_onehot[1];

  // Memory valid is deliberately ignored: the read completes with whatever
  // mem_rdata holds in WAIT_RD, there is no retry path.
  logic unused_mem_valid;
  assign unused_mem_valid = mem_valid;

  // Single FSM with all outputs registered. Pulsed outputs (gnt, rvalid,
  // mem_en) default low every cycle and are raised only by the state that
  // owns them; the command fields hold until the next selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b1;   // requester 0 wins the first contention
      owner_reg       <= 1'b0;
      gnt_reg         <= '0;
      rvalid_reg      <= '0;
      mem_en_reg      <= 1'b0;
      mem_wr_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      rdata_reg       <= '0;
    end else begin
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      mem_en_reg <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg       <= ISSUE;
            owner_reg       <= sel_idx;
            last_served_reg <= sel_idx;
            gnt_reg         <= sel_onehot;
            mem_en_reg      <= 1'b1;
            mem_wr_reg      <= wr_vec[sel_idx];
            mem_addr_reg    <= addr_arr[sel_idx];
            mem_wdata_reg   <= wdata_arr[sel_idx];
          end
        end

        ISSUE: begin
          // Writes finish once the command has been presented.
          state_reg <= mem_wr_reg ? IDLE : WAIT_RD;
        end

        WAIT_RD: begin
          // The memory updated mem_rdata on the edge that took the command.
          rdata_reg <= mem_rdata;
          state_reg <= RESP;
        end

        RESP: begin
          // Pulse lands on the cycle after RESP, while rdata is stable.
          rvalid_reg[owner_reg] <= 1'b1;
          state_reg             <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata     = rdata_reg;
  assign busy      = (state_reg != IDLE);
  assign mem_en    = mem_en_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
